// File: rtl/adc_capture_packer.sv
// ADC capture packer: keeps sample high bytes, packs two beats per 256b word,
// and bursts cap_size bytes through a first-word-fall-through output FIFO.
module adc_capture_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic         rf_clk,
  input  logic         rf_rst,
  input  logic         s_axis_tvalid,
  input  logic [255:0] s_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [255:0] m_axis_tdata,
  output logic         m_axis_tlast,
  input  logic         capture_start,
  input  logic         capture_abort,
  input  logic [31:0]  cap_size,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [26:0]  word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [26:0]  r_n;
  logic         r_phase;
  logic [127:0] r_lo;
  logic [255:0] r_word;
  logic         r_last;
  logic         r_push;
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [256:0] r_mem [FIFO_DEPTH];

  logic [127:0] w_half;
  logic [AW:0]  w_count;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_accept;
  logic [26:0]  w_next;
  logic [26:0]  w_cap_n;
  logic         w_unused;

  always_comb begin
    w_half = '0;
    for (int i = 0; i < 16; i++) begin
      w_half[8*i +: 8] = s_axis_tdata[16*i+8 +: 8];
    end
  end

  assign w_count  = r_wr - r_rd;
  assign w_empty  = (r_wr == r_rd);
  assign w_full   = (w_count == DEPTH_L);
  assign w_pop    = !w_empty && m_axis_tready;
  // A push into a full FIFO still lands if a pop frees a slot this cycle
  assign w_accept = r_push && (!w_full || w_pop);
  assign w_next   = word_count + 27'd1;
  assign w_cap_n  = cap_size[31:5];
  assign w_unused = ^cap_size[4:0];

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : r_mem[r_rd[AW-1:0]][255:0];
  assign m_axis_tlast  = w_empty ? 1'b0 : r_mem[r_rd[AW-1:0]][256];
  assign busy = (r_state == S_CAPTURE) || (r_state == S_FLUSH);

  always_ff @(posedge rf_clk) begin
    if (!rf_rst && !capture_abort && w_accept) begin
      r_mem[r_wr[AW-1:0]] <= {r_last, r_word};
    end
  end

  always_ff @(posedge rf_clk) begin
    if (rf_rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_phase    <= 1'b0;
      r_lo       <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
      r_push     <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else if (capture_abort) begin
      r_state  <= S_IDLE;
      r_phase  <= 1'b0;
      r_push   <= 1'b0;
      r_wr     <= '0;
      r_rd     <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_accept) r_wr <= r_wr + 1'b1;
      if (r_push && !w_accept) overflow <= 1'b1;
      r_push <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (capture_start) begin
            r_n        <= w_cap_n;
            r_phase    <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
            if (w_cap_n != '0) begin
              r_state <= S_CAPTURE;
              done    <= 1'b0;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (s_axis_tvalid) begin
            r_phase <= !r_phase;
            if (!r_phase) begin
              r_lo <= w_half;
            end else begin
              r_word     <= {w_half, r_lo};
              r_last     <= (w_next == r_n);
              r_push     <= 1'b1;
              word_count <= w_next;
              if (w_next == r_n) r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (!r_push && w_empty) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_packer.sv
// Randomized bench for adc_capture_packer against a queue-based model
// of the byte-select, pairing and burst rules.
module tb_adc_capture_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic [255:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [255:0] m_data;
  logic         m_last;
  logic         start;
  logic         abort_i;
  logic [31:0]  cap_size;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [26:0]  word_count;

  int n_chk  = 0;
  int n_pass = 0;
  int rmode  = 0;

  logic [255:0] beats[$];
  logic [256:0] got[$];
  logic [256:0] exp_q[$];

  adc_capture_packer #(.FIFO_DEPTH(8)) dut (
    .rf_clk        (clk),
    .rf_rst        (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tdata  (s_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .capture_start (start),
    .capture_abort (abort_i),
    .cap_size      (cap_size),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [256:0] act,
                       input logic [256:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Ready patterns: 0 always, 1 never, 2 random with >=1 ready per cycle pair
  logic r_pair = 1'b0;
  logic r_second = 1'b1;
  always @(posedge clk) begin
    int p;
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = 1'b0;
      default: begin
        if (!r_pair) begin
          p = $urandom_range(0, 2);
          m_ready = (p != 1);
          r_second = (p != 0);
        end else begin
          m_ready = r_second;
        end
      end
    endcase
    r_pair = !r_pair;
  end

  logic         p_stall = 1'b0;
  logic [256:0] p_out;
  always @(negedge clk) begin
    if (p_stall) check("axis_hold", {m_valid, m_last, m_data[254:0]}, p_out);
    if (m_valid && m_ready) got.push_back({m_last, m_data});
    p_stall = m_valid && !m_ready && !abort_i && !rst;
    p_out   = {m_valid, m_last, m_data[254:0]};
  end

  function automatic logic [127:0] hib(input logic [255:0] b);
    logic [127:0] h;
    for (int i = 0; i < 16; i++) h[8*i +: 8] = b[16*i+8 +: 8];
    return h;
  endfunction

  function automatic logic [255:0] rnd_beat();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] size);
    start    = 1'b1;
    cap_size = size;
    step();
    start    = 1'b0;
    cap_size = $urandom;
  endtask

  task automatic send(input int n, input int gap, input bit pat);
    for (int k = 0; k < n; k++) begin
      logic [255:0] b;
      b = rnd_beat();
      if (pat) begin
        for (int i = 0; i < 16; i++)
          b[16*i +: 16] = {4'(i), 4'(k), 8'hA5};
      end
      beats.push_back(b);
      s_valid = 1'b1;
      s_data  = b;
      step();
      s_valid = 1'b0;
      s_data  = rnd_beat();
      repeat (gap) step();
    end
  endtask

  task automatic build_exp(input int nw, input int keep);
    exp_q.delete();
    for (int j = 0; j < nw && j < keep; j++)
      exp_q.push_back({(j == nw - 1), hib(beats[2*j+1]), hib(beats[2*j])});
  endtask

  task automatic cmp_words(input string tag);
    check({tag, "_nwords"}, 257'(got.size()), 257'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    beats.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      step();
      c++;
    end
    check({tag, "_done"}, 257'(done), 257'(1));
    check({tag, "_busy"}, 257'(busy), 257'(0));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0;
    abort_i = 1'b0; cap_size = '0; m_ready = 1'b1;
    repeat (3) step();
    check("rst_tvalid", 257'(m_valid), 257'(0));
    check("rst_tdata", 257'(m_data), 257'(0));
    check("rst_tlast", 257'(m_last), 257'(0));
    check("rst_flags", 257'({busy, done, overflow}), 257'(0));
    check("rst_wcnt", 257'(word_count), 257'(0));
    rst = 1'b0;
    step();

    // 1: two words; stray beats before start must be ignored
    rmode = 0;
    send(2, 0, 1'b0);
    beats.delete();
    do_start(32'd64);
    check("t1_busy", 257'(busy), 257'(1));
    send(4, 0, 1'b1);
    wait_done("t1", 50);
    build_exp(2, 2);
    cmp_words("t1");
    check("t1_ovf", 257'(overflow), 257'(0));
    check("t1_wcnt", 257'(word_count), 257'(2));

    // 2: size below one word finishes at once
    do_start(32'h1F);
    check("t2_done", 257'(done), 257'(1));
    check("t2_busy", 257'(busy), 257'(0));
    send(4, 0, 1'b0);
    repeat (4) step();
    build_exp(0, 0);
    cmp_words("t2");

    // 3: stalled sink, 20 words into an 8-deep FIFO
    rmode = 1;
    step();
    do_start(32'd640);
    check("t3_done_clr", 257'(done), 257'(0));
    send(40, 0, 1'b0);
    repeat (4) step();
    check("t3_ovf", 257'(overflow), 257'(1));
    check("t3_wcnt", 257'(word_count), 257'(20));
    check("t3_busy", 257'(busy), 257'(1));
    check("t3_held", 257'(m_valid), 257'(1));
    rmode = 0;
    wait_done("t3", 100);
    build_exp(20, 8);
    cmp_words("t3");
    check("t3_ovf_end", 257'(overflow), 257'(1));

    // 4: sparse input, phase follows valid beats only
    do_start(32'd96);
    check("t4_ovf_clr", 257'(overflow), 257'(0));
    send(6, 3, 1'b0);
    wait_done("t4", 100);
    build_exp(3, 3);
    cmp_words("t4");
    check("t4_wcnt", 257'(word_count), 257'(3));

    // 5: abort mid-capture with a word stuck at the output
    rmode = 1;
    step();
    do_start(32'd256);
    send(3, 0, 1'b0);
    step();
    check("t5_pre_valid", 257'(m_valid), 257'(1));
    abort_i = 1'b1;
    start = 1'b1;
    step();
    abort_i = 1'b0;
    start = 1'b0;
    check("t5_valid", 257'(m_valid), 257'(0));
    check("t5_busy", 257'(busy), 257'(0));
    check("t5_flags", 257'({done, overflow}), 257'(0));
    beats.delete();
    got.delete();
    rmode = 0;
    step();
    do_start(32'd64);
    send(4, 0, 1'b0);
    wait_done("t5", 50);
    build_exp(2, 2);
    cmp_words("t5");

    // 6: long full-rate capture with random ready
    rmode = 2;
    do_start(32'd32000);
    send(2000, 0, 1'b0);
    wait_done("t6", 200);
    build_exp(1000, 1000);
    cmp_words("t6");
    check("t6_ovf", 257'(overflow), 257'(0));
    check("t6_wcnt", 257'(word_count), 257'(1000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
